// File: rtl/round_iterator_pkg.sv
// Shared AES definitions for the round iterator: round count derivation,
// key-size legality, FSM state encoding and the combinational AES round
// transforms (Round, RoundInverse, FinalRound, FinalRoundInverse).
package round_iterator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Number of cipher rounds for a given key width in bits.
    function automatic int calc_nr(input int key_size);
        return key_size / 32 + 6;
    endfunction

    // Only the three AES key widths are meaningful.
    function automatic bit key_size_ok(input int key_size);
        return (key_size == 128) || (key_size == 192) || (key_size == 256);
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = xtime(aa);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            r = e[i] ? gf_mul(r, p) : r;
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    // Byte 0 of the block is the most significant byte; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = inv ? sbox_inv(s[127-8*i -: 8]) : sbox_fwd(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                src = inv ? (4 * ((c - row + 4) % 4) + row) : (4 * ((c + row) % 4) + row);
                r[127-8*(4*c+row) -: 8] = s[127-8*src -: 8];
            end
        end
        return r;
    endfunction

    // Circulant matrix multiply per column; row i uses coef[(j - i) mod 4] for byte j.
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [31:0]  cf;
        logic [7:0]   acc;
        r  = '0;
        cf = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gf_mul(cf[31-8*((j-i+4)%4) -: 8], s[127-8*(4*c+j) -: 8]);
                end
                r[127-8*(4*c+i) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ k;
    endfunction

    function automatic logic [127:0] aes_final(input logic [127:0] s, input logic [127:0] k);
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ k;
    endfunction

    // Straight inverse cipher ordering, so the normal key schedule is usable.
    function automatic logic [127:0] aes_round_inv(input logic [127:0] s, input logic [127:0] k);
        return mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k, 1'b1);
    endfunction

    function automatic logic [127:0] aes_final_inv(input logic [127:0] s, input logic [127:0] k);
        return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    endfunction

endpackage

// File: rtl/round_iterator.sv
// Iterative AES engine: one round per clock, encrypt or decrypt selected at
// accept, valid/ready handshakes on both sides, key schedule latched per block.
module round_iterator
    import round_iterator_pkg::*;
#(
    parameter int KEY_SIZE = 128,
    localparam int NR = calc_nr(KEY_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [127:0]          data_in,
    input  logic [(NR+1)*128-1:0] key_schedule,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          data_out,
    output logic                  busy
);

    localparam logic [3:0] NR_W = 4'(NR);

    if (!key_size_ok(KEY_SIZE)) begin : g_bad_key_size
        $fatal(1, "round_iterator: KEY_SIZE must be 128, 192 or 256");
    end

    fsm_e                  fsm_q;
    logic [127:0]          state_q;
    logic [3:0]            round_q;
    logic                  mode_q;
    logic [(NR+1)*128-1:0] ks_q;
    logic                  idle_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic                  accept_s;
    logic [127:0]          load_key_s;
    logic [127:0]          load_d;
    logic [3:0]            rk_idx_s;
    logic [127:0]          round_key_s;
    logic [127:0]          round_d;

    // In DONE the slot frees on the same edge the result is taken, so ready follows out_ready.
    assign in_ready  = idle_q | (out_valid_q & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = state_q;

    // Initial key whitening of the incoming block with rk[0] or rk[NR].
    always_comb begin
        load_key_s = '0;
        if (mode) begin
            load_key_s = key_schedule[NR*128 +: 128];
        end else begin
            load_key_s = key_schedule[127:0];
        end
        load_d = data_in ^ load_key_s;
    end

    // Round key pick and round transform for the current round using latched mode/keys.
    always_comb begin
        rk_idx_s    = mode_q ? (NR_W - round_q) : round_q;
        round_key_s = ks_q[rk_idx_s*128 +: 128];
        round_d     = '0;
        if (round_q == NR_W) begin
            if (mode_q) begin
                round_d = aes_final_inv(state_q, round_key_s);
            end else begin
                round_d = aes_final(state_q, round_key_s);
            end
        end else begin
            if (mode_q) begin
                round_d = aes_round_inv(state_q, round_key_s);
            end else begin
                round_d = aes_round(state_q, round_key_s);
            end
        end
    end

    // Sequencer: load on accept, one round per edge in RUN, hold the result in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            round_q     <= 4'd0;
            mode_q      <= 1'b0;
            ks_q        <= '0;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept_s) begin
            fsm_q       <= ST_RUN;
            state_q     <= load_d;
            round_q     <= 4'd1;
            mode_q      <= mode;
            ks_q        <= key_schedule;
            idle_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    fsm_q <= ST_IDLE;
                end
                ST_RUN: begin
                    state_q <= round_d;
                    if (round_q == NR_W) begin
                        fsm_q       <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        idle_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        fsm_q <= ST_DONE;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    idle_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_iterator.sv
// Directed bench for round_iterator at all three key sizes against FIPS-197
// Appendix C vectors, plus stall, back-to-back, mid-run reset and
// input-disturbance sequences.
module tb_round_iterator;

    logic         clock;
    logic         reset_n   [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         mode_i    [3];
    logic [127:0] din       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] dout      [3];
    logic         busy      [3];
    logic [1407:0] ks128;
    logic [1663:0] ks192;
    logic [1919:0] ks256;

    logic [7:0]    tb_sbox [256];
    logic [1919:0] full_ks [3];
    int            checks;
    int            failures;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    round_iterator #(.KEY_SIZE(128)) dut128 (
        .clock(clock), .reset_n(reset_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode_i[0]), .data_in(din[0]), .key_schedule(ks128), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .data_out(dout[0]), .busy(busy[0])
    );
    round_iterator #(.KEY_SIZE(192)) dut192 (
        .clock(clock), .reset_n(reset_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode_i[1]), .data_in(din[1]), .key_schedule(ks192), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .data_out(dout[1]), .busy(busy[1])
    );
    round_iterator #(.KEY_SIZE(256)) dut256 (
        .clock(clock), .reset_n(reset_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode_i[2]), .data_in(din[2]), .key_schedule(ks256), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .data_out(dout[2]), .busy(busy[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int           k;
        logic         mode;
        logic [127:0] din;
        logic [127:0] dout;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs [6];

    // S-box built from the generator-3 log walk (stimulus only: key expansion).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            tb_sbox[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end while (p != 8'h01);
        tb_sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; key is left-aligned in 256 bits, rk[r] at [128r +: 128].
    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            nr;
        nr = nk + 6;
        r  = '0;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j <= nr; j++) r[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    task automatic set_ks(input int k, input logic [1919:0] v);
        case (k)
            0: ks128 = v[1407:0];
            1: ks192 = v[1663:0];
            default: ks256 = v;
        endcase
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; counts rising edges until out_valid, bounded.
    task automatic wait_out(input int k, output int edges);
        edges = 0;
        while (out_valid[k] !== 1'b1 && edges < 40) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
    endtask

    task automatic consume(input int k, input string name);
        out_ready[k] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready[k] = 1'b0;
        check1({name, " out_valid after take"}, out_valid[k], 1'b0);
        check1({name, " in_ready after take"}, in_ready[k], 1'b1);
    endtask

    task automatic run_block(input int k, input logic m, input logic [127:0] d,
                             input logic [127:0] exp, input int lat, input string name);
        int e;
        @(negedge clock);
        check1({name, " in_ready idle"}, in_ready[k], 1'b1);
        in_valid[k] = 1'b1;
        mode_i[k]   = m;
        din[k]      = d;
        set_ks(k, full_ks[k]);
        @(posedge clock);
        @(negedge clock);
        in_valid[k] = 1'b0;
        din[k]      = '0;
        check1({name, " busy in run"}, busy[k], 1'b1);
        check1({name, " in_ready in run"}, in_ready[k], 1'b0);
        wait_out(k, e);
        check_int({name, " latency"}, e, lat);
        check128({name, " data"}, dout[k], exp);
        check1({name, " busy done"}, busy[k], 1'b0);
        consume(k, name);
    endtask

    initial begin
        int e;
        int seen;
        logic [1919:0] junk;
        checks   = 0;
        failures = 0;
        ks128    = '0;
        ks192    = '0;
        ks256    = '0;
        for (int k = 0; k < 3; k++) begin
            reset_n[k]   = 1'b0;
            in_valid[k]  = 1'b0;
            mode_i[k]    = 1'b0;
            din[k]       = '0;
            out_ready[k] = 1'b0;
        end
        build_sbox();
        full_ks[0] = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        full_ks[1] = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        full_ks[2] = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        vecs[0] = '{0, 1'b0, PT,    CT128, 10, "enc128"};
        vecs[1] = '{1, 1'b0, PT,    CT192, 12, "enc192"};
        vecs[2] = '{2, 1'b0, PT,    CT256, 14, "enc256"};
        vecs[3] = '{0, 1'b1, CT128, PT,    10, "dec128"};
        vecs[4] = '{1, 1'b1, CT192, PT,    12, "dec192"};
        vecs[5] = '{2, 1'b1, CT256, PT,    14, "dec256"};

        // Reset state
        #12;
        for (int k = 0; k < 3; k++) begin
            check1("reset in_ready", in_ready[k], 1'b1);
            check1("reset out_valid", out_valid[k], 1'b0);
            check1("reset busy", busy[k], 1'b0);
            check128("reset data_out", dout[k], 128'h0);
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) reset_n[k] = 1'b1;

        // Table of known-answer vectors
        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].k, vecs[v].mode, vecs[v].din, vecs[v].dout, vecs[v].lat, vecs[v].name);
        end

        // Output stall for 5 cycles, then output take and new accept on the same edge
        @(negedge clock);
        in_valid[0] = 1'b1; mode_i[0] = 1'b0; din[0] = PT; set_ks(0, full_ks[0]);
        @(posedge clock);
        @(negedge clock);
        in_valid[0] = 1'b0;
        wait_out(0, e);
        check_int("stall latency", e, 10);
        check128("stall first data", dout[0], CT128);
        in_valid[0] = 1'b1; mode_i[0] = 1'b1; din[0] = CT128;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            @(negedge clock);
            check128("stall data hold", dout[0], CT128);
            check1("stall out_valid hold", out_valid[0], 1'b1);
            check1("stall in_ready low", in_ready[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        #1;
        check1("b2b in_ready follows out_ready", in_ready[0], 1'b1);
        @(posedge clock);
        @(negedge clock);
        in_valid[0] = 1'b0; out_ready[0] = 1'b0; din[0] = '0;
        check1("b2b busy", busy[0], 1'b1);
        check1("b2b out_valid dropped", out_valid[0], 1'b0);
        wait_out(0, e);
        check_int("b2b latency", e, 10);
        check128("b2b data", dout[0], PT);
        consume(0, "b2b");

        // Reset pulse in the middle of a block
        @(negedge clock);
        in_valid[0] = 1'b1; mode_i[0] = 1'b0; din[0] = PT; set_ks(0, full_ks[0]);
        @(posedge clock);
        @(negedge clock);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset_n[0] = 1'b0;
        #1;
        check1("midreset out_valid", out_valid[0], 1'b0);
        check1("midreset busy", busy[0], 1'b0);
        check1("midreset in_ready", in_ready[0], 1'b1);
        check128("midreset data_out", dout[0], 128'h0);
        @(negedge clock);
        reset_n[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (out_valid[0] === 1'b1) seen++;
        end
        check_int("midreset no stray out_valid", seen, 0);
        run_block(0, 1'b0, PT, CT128, 10, "after reset");

        // Input disturbance while a 192-bit block is in flight
        @(negedge clock);
        in_valid[1] = 1'b1; mode_i[1] = 1'b0; din[1] = PT; set_ks(1, full_ks[1]);
        @(posedge clock);
        e = 0;
        @(negedge clock);
        while (out_valid[1] !== 1'b1 && e < 40) begin
            for (int w = 0; w < 60; w++) junk[32*w +: 32] = $urandom;
            in_valid[1] = 1'($urandom_range(1, 0));
            mode_i[1]   = 1'($urandom_range(1, 0));
            din[1]      = {$urandom, $urandom, $urandom, $urandom};
            set_ks(1, junk);
            @(posedge clock);
            e++;
            @(negedge clock);
        end
        in_valid[1] = 1'b0;
        set_ks(1, full_ks[1]);
        check_int("disturb latency", e, 12);
        check128("disturb data", dout[1], CT192);
        consume(1, "disturb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_iterator.md
ROUND_ITERATOR -- requirements
Module: round_iterator

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 128, cipher key width in bits; legal values 128, 192, 256.
REQ-002 SHALL derive localparam NR = KEY_SIZE/32 + 6, giving 10, 12 or 14 rounds.
REQ-003 SHALL have port clock  input  1  single clock for all state; rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  block offered on data_in.
REQ-006 SHALL have port in_ready  output  1  block accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-008 SHALL have port data_in  input  128  plaintext (mode 0) or ciphertext (mode 1).
REQ-009 SHALL have port key_schedule  input  (NR+1)*128  expanded round keys, rk[i] at bits [128*i +: 128]; sampled at accept.
REQ-010 SHALL have port out_valid  output  1  data_out holds a finished block.
REQ-011 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
REQ-012 SHALL have port data_out  output  128  result block.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 in IDLE, out_ready in DONE, 0 in RUN.
REQ-016 On accept: state register <= data_in XOR rk[0] (enc) or rk[NR] (dec); round counter <= 1; mode, key_schedule latched; FSM -> RUN.
REQ-017 In RUN, each edge with round r < NR SHALL apply Round with rk[r] (enc) or RoundInverse with rk[NR-r] (dec) and increment r.
REQ-018 At r == NR SHALL apply FinalRound (enc) or FinalRoundInverse (dec) with rk[NR] / rk[0], FSM -> DONE.
REQ-019 out_valid SHALL rise exactly NR clock edges after the accept edge; latency 10/12/14.
REQ-020 In DONE, data_out and out_valid SHALL hold stable until out_ready; on handshake -> IDLE unless a new accept occurs same edge.
REQ-021 Simultaneous output handshake and input accept in DONE SHALL go directly to RUN with the new block; no bubble cycle.
REQ-022 in_valid while in RUN SHALL be ignored; no input is lost because in_ready is 0.
REQ-023 Changes to mode or key_schedule after accept SHALL NOT affect the block in flight.
REQ-024 data_out SHALL equal the state register; its value outside DONE is don't-care but SHALL be deterministic.
REQ-025 Round counter width SHALL be 4 bits; no wrap occurs for any legal KEY_SIZE.

Reset
REQ-026 reset_n low SHALL immediately force FSM=IDLE, out_valid=0, busy=0, in_ready=1, counter=0, data_out=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the block without producing out_valid.
REQ-028 Deassertion SHALL be synchronised externally; block accepts input on the first edge after release.

Structure
REQ-029 NR derivation, the FSM state enum and KEY_SIZE legality check SHALL live in the shared AES package.
REQ-030 SHALL instantiate existing Round, RoundInverse, FinalRound, FinalRoundInverse combinationally with a mode mux; no new sub-module.
REQ-031 Illegal KEY_SIZE SHALL fail elaboration.

Verification
REQ-032 KEY_SIZE=128, enc, key 000102..0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 edges after accept.
REQ-033 KEY_SIZE=192 and 256, FIPS-197 App. C keys, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089 at latency 12 / 14.
REQ-034 Decrypt each App. C ciphertext -> 00112233445566778899aabbccddeeff at same latency.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid -> data_out stable, in_ready=0; then out_ready=1 with in_valid=1 -> next block accepted same edge, back-to-back results correct.
REQ-036 Pulse reset_n low at round 5 -> outputs reset immediately, no out_valid; next block completes correctly.
REQ-037 Toggle in_valid, mode, key_schedule during RUN -> result unchanged from first accepted block.
